seq_multi: RTL and testbench

//  Parametrised sequential shift-add multiplier, successor to the 4x4 combinational multiplier.

---
 rtl/seq_multi_pkg.sv | 16 +
 rtl/seq_multi_twos_abs.sv | 17 +
 rtl/seq_multi.sv | 114 +++++++++++
 tb/tb_seq_multi.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_multi_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_e    : FSM state encodings (IDLE=0, RUN=1, FIN=2)
//   cnt_width  : bits needed for a step counter that must reach WIDTH
package seq_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_multi_twos_abs.sv
// Combinational conditional two's-complement negate.
//   in_i  : N-bit input value
//   neg_i : 1 = output the negation of in_i, 0 = pass through
//   out_o : N-bit result (neg_i ? -in_i : in_i), wraps modulo 2^N
// Used both to take operand magnitudes and to apply the final result sign.
module twos_abs #(
  parameter int N = 4
) (
  input  logic [N-1:0] in_i,
  input  logic         neg_i,
  output logic [N-1:0] out_o
);

  // -0 is 0 and -(-2^(N-1)) is 2^(N-1) read as unsigned, both exact here.
  assign out_o = neg_i ? (N'(0) - in_i) : in_i;

endmodule

// File: rtl/seq_multi.sv
// Sequential shift-add multiplier: C = A*B over WIDTH+1 RUN cycles.
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   START : request, accepted in IDLE or FIN
//   SGN   : 1 = two's-complement operands/result, 0 = unsigned
//   A, B  : WIDTH-bit multiplicand / multiplier, sampled with START
//   C     : 2*WIDTH-bit registered product, held until the next result
//   BUSY  : high while in RUN
//   DONE  : one-cycle pulse in FIN, C holds a new result
module seq_multi
  import seq_multi_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 SGN,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   C,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    c_q, c_d;
  logic             sign_q, sign_d;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    result;

  assign neg_a = SGN & A[WIDTH-1];
  assign neg_b = SGN & B[WIDTH-1];

  twos_abs #(.N(WIDTH)) u_abs_a (.in_i(A),     .neg_i(neg_a),  .out_o(a_mag));
  twos_abs #(.N(WIDTH)) u_abs_b (.in_i(B),     .neg_i(neg_b),  .out_o(b_mag));
  twos_abs #(.N(PW))    u_sign  (.in_i(acc_q), .neg_i(sign_q), .out_o(result));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    c_d     = c_q;
    sign_d  = sign_q;

    unique case (state_q)
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        if (START) begin
          mcand_d = {{WIDTH{1'b0}}, a_mag};
          mplr_d  = b_mag;
          sign_d  = neg_a ^ neg_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == LAST_CNT) begin
          // All WIDTH bits consumed: publish the signed result.
          c_d     = result;
          state_d = ST_FIN;
        end else begin
          // Multiplicand is pre-shifted each step, so it always sits at the
          // weight of the multiplier bit currently in mplr_q[0].
          if (mplr_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      sign_q  <= sign_d;
    end
  end

  assign C    = c_q;
  assign BUSY = (state_q == ST_RUN);
  assign DONE = (state_q == ST_FIN);

endmodule

// File: tb/tb_seq_multi.sv
module tb_seq_multi;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;

  logic        START4 = 1'b0, SGN4 = 1'b0;
  logic [3:0]  A4 = '0, B4 = '0;
  logic [7:0]  C4;
  logic        BUSY4, DONE4;

  logic        START8 = 1'b0, SGN8 = 1'b0;
  logic [7:0]  A8 = '0, B8 = '0;
  logic [15:0] C8;
  logic        BUSY8, DONE8;

  seq_multi #(.WIDTH(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .START(START4), .SGN(SGN4),
    .A(A4), .B(B4), .C(C4), .BUSY(BUSY4), .DONE(DONE4)
  );

  seq_multi #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .START(START8), .SGN(SGN8),
    .A(A8), .B(B8), .C(C8), .BUSY(BUSY8), .DONE(DONE8)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] c;
    int          issue;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sgn;
    logic [7:0] c;
  } vec_t;
  vec_t tbl[7];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b, input logic sgn);
    int ai, bi, p;
    ai = sgn ? int'($signed(a)) : int'(a);
    bi = sgn ? int'($signed(b)) : int'(b);
    p  = ai * bi;
    return p[7:0];
  endfunction

  // Bounded wait for DONE4 at negedges; returns 1 if seen.
  task automatic wait_done4(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (DONE4 === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic wait_done8(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (DONE8 === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  // Pop the scoreboard head and compare it with the DUT4 result on DONE.
  task automatic retire4(input string name);
    bit   seen;
    exp_t e;
    wait_done4(seen);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      if (!seen) begin
        chk({name, "_timeout"}, 32'd0, 32'd1);
      end else begin
        chk(name, {24'd0, C4}, {24'd0, e.c[7:0]});
        chk({name, "_latency"}, cyc - e.issue, 32'd5);
      end
    end
    @(negedge CLK);
    chk({name, "_done_pulse"}, {31'd0, DONE4}, 32'd0);
  endtask

  // Issue one WIDTH=4 operation at the next edge and check its result.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sgn,
                     input logic [7:0] exp_c, input string name);
    exp_t e;
    @(negedge CLK);
    A4 = a; B4 = b; SGN4 = sgn; START4 = 1'b1;
    e.c = {8'd0, exp_c};
    e.issue = cyc + 1;
    sb.push_back(e);
    @(negedge CLK);
    START4 = 1'b0;
    chk({name, "_busy"}, {31'd0, BUSY4}, 32'd1);
    retire4(name);
  endtask

  initial begin
    bit   seen;
    exp_t e;
    int   done_cnt;
    int   done1_cyc;

    tbl[0] = '{a: 4'hF, b: 4'hF, sgn: 1'b0, c: 8'hE1};
    tbl[1] = '{a: 4'h8, b: 4'h8, sgn: 1'b1, c: 8'h40};
    tbl[2] = '{a: 4'h8, b: 4'h7, sgn: 1'b1, c: 8'hC8};
    tbl[3] = '{a: 4'hF, b: 4'h1, sgn: 1'b1, c: 8'hFF};
    tbl[4] = '{a: 4'h0, b: 4'h8, sgn: 1'b1, c: 8'h00};
    tbl[5] = '{a: 4'h7, b: 4'h7, sgn: 1'b1, c: 8'h31};
    tbl[6] = '{a: 4'hD, b: 4'hA, sgn: 1'b1, c: 8'h12};

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_c4",    {24'd0, C4},    32'd0);
    chk("rst_busy4", {31'd0, BUSY4}, 32'd0);
    chk("rst_done4", {31'd0, DONE4}, 32'd0);
    chk("rst_c8",    {16'd0, C8},    32'd0);
    chk("rst_busy8", {31'd0, BUSY8}, 32'd0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_c4",    {24'd0, C4},    32'd0);
    chk("idle_busy4", {31'd0, BUSY4}, 32'd0);
    chk("idle_done4", {31'd0, DONE4}, 32'd0);

    // Spec-listed vectors
    foreach (tbl[i]) op4(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].c, $sformatf("tbl%0d", i));

    // Exhaustive unsigned WIDTH=4
    for (int b = 0; b < 16; b++) begin
      for (int a = 0; a < 16; a++) begin
        op4(4'(a), 4'(b), 1'b0, model4(4'(a), 4'(b), 1'b0), $sformatf("u_%0d_%0d", a, b));
      end
    end

    // A few signed pairs from the model
    for (int i = 0; i < 12; i++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      op4(ra, rb, 1'b1, model4(ra, rb, 1'b1), $sformatf("s_%0h_%0h", ra, rb));
    end

    // START during RUN is ignored
    @(negedge CLK);
    A4 = 4'd3; B4 = 4'd5; SGN4 = 1'b0; START4 = 1'b1;
    e.c = 16'h000F; e.issue = cyc + 1;
    sb.push_back(e);
    @(negedge CLK);
    START4 = 1'b0;
    @(negedge CLK);
    A4 = 4'd7; B4 = 4'd7; START4 = 1'b1;
    @(negedge CLK);
    START4 = 1'b0;
    retire4("ignore_start");
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (DONE4) done_cnt++;
      @(negedge CLK);
    end
    chk("ignore_extra_done", done_cnt, 32'd0);
    chk("ignore_c_held", {24'd0, C4}, 32'h0F);

    // Asynchronous reset mid-operation
    @(negedge CLK);
    A4 = 4'd9; B4 = 4'd9; SGN4 = 1'b0; START4 = 1'b1;
    @(negedge CLK);
    START4 = 1'b0;
    chk("abort_busy_before", {31'd0, BUSY4}, 32'd1);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("abort_c",    {24'd0, C4},    32'd0);
    chk("abort_busy", {31'd0, BUSY4}, 32'd0);
    chk("abort_done", {31'd0, DONE4}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    op4(4'd2, 4'd6, 1'b0, 8'h0C, "after_abort");

    // WIDTH=8 back-to-back with START held through FIN
    @(negedge CLK);
    A8 = 8'd255; B8 = 8'd255; SGN8 = 1'b0; START8 = 1'b1;
    e.c = 16'hFE01; e.issue = cyc + 1;
    sb.push_back(e);
    e.c = 16'h0002; e.issue = cyc + 11;
    sb.push_back(e);
    @(negedge CLK);
    A8 = 8'd1; B8 = 8'd2;
    chk("w8_busy", {31'd0, BUSY8}, 32'd1);
    wait_done8(seen);
    e = sb.pop_front();
    chk("w8_first_seen", {31'd0, seen}, 32'd1);
    chk("w8_first", {16'd0, C8}, {16'd0, e.c});
    chk("w8_first_latency", cyc - e.issue, 32'd9);
    done1_cyc = cyc;
    @(negedge CLK);
    START8 = 1'b0;
    chk("w8_second_accepted", {31'd0, BUSY8}, 32'd1);
    wait_done8(seen);
    e = sb.pop_front();
    chk("w8_second_seen", {31'd0, seen}, 32'd1);
    chk("w8_second", {16'd0, C8}, {16'd0, e.c});
    chk("w8_interval", cyc - done1_cyc, 32'd10);
    @(negedge CLK);
    chk("w8_done_pulse", {31'd0, DONE8}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
